branch_sequencer: RTL and testbench

- Control-unit slice that executes conditional branch instructions.
- On each branch it pulses the CON flip-flop load enable, then reads back the evaluated condition flag.
- It then conditionally loads PC with PC + sign-extended C.
- It sits between the instruction decoder and the datapath/CON logic, and keeps taken/not-taken statistics for debug.

---
 rtl/branch_sequencer_if.sv | 36 +++
 rtl/branch_sequencer.sv | 87 ++++++++
 tb/tb_branch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Handshake and datapath strobe bundle between the decoder/datapath and the branch sequencer.
// The decoder side is the master (issues start/stall/con_ff); the sequencer is the slave.
interface branch_sequencer_if #(
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          con_ff;
  logic          gra;
  logic          r_out;
  logic          con_in;
  logic          pc_out;
  logic          y_in;
  logic          c_out;
  logic          alu_add;
  logic          z_in;
  logic          z_low_out;
  logic          pc_in;
  logic          busy;
  logic          done;
  logic          branch_taken;
  logic [CW-1:0] taken_count;
  logic [CW-1:0] not_taken_count;

  modport master (
    output start, stall, con_ff,
    input  gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, z_low_out, pc_in,
    input  busy, done, branch_taken, taken_count, not_taken_count
  );

  modport slave (
    input  start, stall, con_ff,
    output gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in, z_low_out, pc_in,
    output busy, done, branch_taken, taken_count, not_taken_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// Conditional-branch control slice: CON load, PC + sign-extended C, conditional PC load,
// plus saturating taken/not-taken statistics.
//
// state | meaning
// IDLE  | waiting for start, all strobes low
// T3    | Ra onto bus, load CON flip-flop
// T4    | PC onto bus, load Y
// T5    | C onto bus, ALU add, load Z
// T6    | Z low onto bus, load PC only if con_ff
module branch_sequencer #(
  parameter int CW = 16
) (
  input logic               clock,
  input logic               reset,
  branch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4
  } state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state;
  logic          done_q;
  logic          taken_q;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] not_taken_cnt;
  logic          run;

  assign run = !bus.stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      done_q        <= 1'b0;
      taken_q       <= 1'b0;
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) state <= T3;
        T3:   if (run) state <= T4;
        T4:   if (run) state <= T5;
        T5:   if (run) state <= T6;
        T6: begin
          if (run) begin
            state   <= IDLE;
            done_q  <= 1'b1;
            taken_q <= bus.con_ff;
            // statistics saturate so a long debug run never reports a wrapped count
            if (bus.con_ff) begin
              if (taken_cnt != '1) taken_cnt <= taken_cnt + ONE;
            end else begin
              if (not_taken_cnt != '1) not_taken_cnt <= not_taken_cnt + ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // strobes are same-cycle decodes so a stall blanks them without waiting a clock
  assign bus.gra       = (state == T3) && run;
  assign bus.r_out     = (state == T3) && run;
  assign bus.con_in    = (state == T3) && run;
  assign bus.pc_out    = (state == T4) && run;
  assign bus.y_in      = (state == T4) && run;
  assign bus.c_out     = (state == T5) && run;
  assign bus.alu_add   = (state == T5) && run;
  assign bus.z_in      = (state == T5) && run;
  assign bus.z_low_out = (state == T6) && run;
  assign bus.pc_in     = (state == T6) && run && bus.con_ff;

  assign bus.busy            = (state != IDLE);
  assign bus.done            = done_q;
  assign bus.branch_taken    = taken_q;
  assign bus.taken_count     = taken_cnt;
  assign bus.not_taken_count = not_taken_cnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: a CW=16 instance for sequencing checks and a
// CW=2 instance for counter saturation.
module tb_branch_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  branch_sequencer_if #(.CW(16)) if0 ();
  branch_sequencer_if #(.CW(2))  if1 ();

  branch_sequencer #(.CW(16)) dut0 (.clock(clock), .reset(reset), .bus(if0.slave));
  branch_sequencer #(.CW(2))  dut1 (.clock(clock), .reset(reset), .bus(if1.slave));

  int   n_chk  = 0;
  int   n_fail = 0;
  int   tc_m   = 0;
  int   nt_m   = 0;
  logic exp_q[$];
  int   exp_q1[$];

  function automatic logic [9:0] obs0();
    return {if0.gra, if0.r_out, if0.con_in, if0.pc_out, if0.y_in,
            if0.c_out, if0.alu_add, if0.z_in, if0.z_low_out, if0.pc_in};
  endfunction

  // expected {gra,r_out,con_in,pc_out,y_in,c_out,alu_add,z_in,z_low_out,pc_in}
  function automatic logic [9:0] exp_strobes(int step, logic stl, logic con);
    logic [9:0] e;
    e = '0;
    if (!stl) begin
      case (step)
        3: e = 10'b1110000000;
        4: e = 10'b0001100000;
        5: e = 10'b0000011100;
        6: e = {8'b0, 1'b1, con};
        default: e = '0;
      endcase
    end
    return e;
  endfunction

  task automatic check_counts(string tag);
    n_chk++;
    if (if0.taken_count !== 16'(tc_m)) begin
      n_fail++;
      $display("FAIL %s taken_count: got %0d want %0d", tag, if0.taken_count, tc_m);
    end
    n_chk++;
    if (if0.not_taken_count !== 16'(nt_m)) begin
      n_fail++;
      $display("FAIL %s not_taken_count: got %0d want %0d", tag, if0.not_taken_count, nt_m);
    end
  endtask

  // One branch on dut0; optional stall of stall_len cycles while in step stall_step.
  // con_ff is driven inverted outside T6 so any early sampling shows up.
  task automatic run_branch(input logic con, input int stall_step, input int stall_len, input string tag);
    int         step;
    int         stalls;
    int         con_pulses;
    int         cycles;
    logic       want;
    logic [9:0] e;
    if0.start  = 1'b1;
    if0.con_ff = ~con;
    exp_q.push_back(con);
    @(posedge clock); #1;
    if0.start  = 1'b0;
    step = 3; stalls = 0; con_pulses = 0; cycles = 1;
    for (int g = 0; g < 30 && step <= 6; g++) begin
      if0.stall  = (step == stall_step) && (stalls < stall_len);
      if0.con_ff = (step == 6) ? con : ~con;
      #1;
      e = exp_strobes(step, if0.stall, con);
      n_chk++;
      if (obs0() !== e) begin
        n_fail++;
        $display("FAIL %s strobes T%0d stall=%0b: got %b want %b", tag, step, if0.stall, obs0(), e);
      end
      n_chk++;
      if (if0.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy T%0d: got %b want 1", tag, step, if0.busy);
      end
      if (if0.con_in === 1'b1) con_pulses++;
      if (if0.stall) stalls++; else step++;
      @(posedge clock); #1;
      cycles++;
    end
    if0.stall  = 1'b0;
    if0.con_ff = 1'b0;
    #1;
    n_chk++;
    if (if0.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done at cycle %0d: got %b want 1", tag, cycles, if0.done);
    end
    n_chk++;
    if (cycles != 5 + stall_len) begin
      n_fail++;
      $display("FAIL %s done latency: got %0d want %0d", tag, cycles, 5 + stall_len);
    end
    n_chk++;
    if (if0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy after T6: got %b want 0", tag, if0.busy);
    end
    n_chk++;
    if (con_pulses != 1) begin
      n_fail++;
      $display("FAIL %s con_in pulses: got %0d want 1", tag, con_pulses);
    end
    want = exp_q.pop_front();
    if (want) tc_m++; else nt_m++;
    n_chk++;
    if (if0.branch_taken !== want) begin
      n_fail++;
      $display("FAIL %s branch_taken: got %b want %b", tag, if0.branch_taken, want);
    end
    check_counts(tag);
    @(posedge clock); #1;
    n_chk++;
    if (if0.done !== 1'b0 || if0.branch_taken !== want) begin
      n_fail++;
      $display("FAIL %s after done: got done=%b taken=%b want done=0 taken=%b",
               tag, if0.done, if0.branch_taken, want);
    end
  endtask

  task automatic test_reset();
    if0.start = 1'b0; if0.stall = 1'b0; if0.con_ff = 1'b0;
    if1.start = 1'b0; if1.stall = 1'b0; if1.con_ff = 1'b0;
    reset = 1'b1;
    #12;
    n_chk++;
    if ({obs0(), if0.busy, if0.done, if0.branch_taken} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b want 0", {obs0(), if0.busy, if0.done, if0.branch_taken});
    end
    check_counts("reset");
    reset = 1'b0;
    @(posedge clock); #1;
    n_chk++;
    if (if0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle after reset busy: got %b want 0", if0.busy);
    end
  endtask

  task automatic test_taken();
    run_branch(1'b1, 0, 0, "taken");
  endtask

  task automatic test_not_taken();
    run_branch(1'b0, 0, 0, "not_taken");
  endtask

  task automatic test_stall();
    run_branch(1'b1, 4, 3, "stall_t4");
    run_branch(1'b0, 6, 2, "stall_t6");
  endtask

  task automatic test_back_to_back();
    logic want;
    logic con;
    int   b;
    int   tc0;
    int   nt0;
    tc0 = tc_m; nt0 = nt_m;
    if0.start = 1'b1; if0.stall = 1'b0; if0.con_ff = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      b   = (k - 1) / 5;
      con = (b % 2 == 0);
      if (k % 5 == 1) exp_q.push_back(con);
      if0.con_ff = con;
      if (k == 20) if0.start = 1'b0;
      #1;
      n_chk++;
      if (if0.done !== (k % 5 == 0) || if0.busy !== (k % 5 != 0)) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: got done=%b busy=%b want done=%b busy=%b",
                 k, if0.done, if0.busy, (k % 5 == 0), (k % 5 != 0));
      end
      if (k % 5 == 0 && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        if (want) tc_m++; else nt_m++;
        n_chk++;
        if (if0.branch_taken !== want) begin
          n_fail++;
          $display("FAIL b2b branch_taken %0d: got %b want %b", b, if0.branch_taken, want);
        end
        check_counts("b2b");
      end
    end
    n_chk++;
    if (tc_m - tc0 != 2 || nt_m - nt0 != 2) begin
      n_fail++;
      $display("FAIL b2b totals: got %0d/%0d want 2/2", tc_m - tc0, nt_m - nt0);
    end
    @(posedge clock); #1;
    n_chk++;
    if (if0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b start dropped busy: got %b want 0", if0.busy);
    end
  endtask

  task automatic test_async_reset();
    run_branch(1'b1, 0, 0, "pre_reset");
    if0.start = 1'b1; if0.con_ff = 1'b1;
    @(posedge clock); #1;
    if0.start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_chk++;
    if (if0.z_in !== 1'b1) begin
      n_fail++;
      $display("FAIL async pre T5 z_in: got %b want 1", if0.z_in);
    end
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({obs0(), if0.busy, if0.done, if0.branch_taken} !== 13'b0) begin
      n_fail++;
      $display("FAIL async reset outputs: got %b want 0", {obs0(), if0.busy, if0.done, if0.branch_taken});
    end
    exp_q.delete();
    tc_m = 0; nt_m = 0;
    check_counts("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_chk++;
      if (if0.pc_in !== 1'b0 || if0.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL async hold cycle %0d: got pc_in=%b busy=%b want 0 0", i, if0.pc_in, if0.busy);
      end
    end
    reset = 1'b0;
    @(posedge clock); #1;
    run_branch(1'b0, 0, 0, "post_reset");
  endtask

  task automatic test_saturation();
    int want;
    if1.stall = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      exp_q1.push_back((i > 3) ? 3 : i);
      if1.start  = 1'b1;
      if1.con_ff = 1'b1;
      @(posedge clock); #1;
      if1.start = 1'b0;
      for (int g = 0; g < 10 && if1.done !== 1'b1; g++) begin
        @(posedge clock); #1;
      end
      n_chk++;
      if (if1.done !== 1'b1) begin
        n_fail++;
        $display("FAIL sat branch %0d done timeout: got %b want 1", i, if1.done);
      end
      want = exp_q1.pop_front();
      n_chk++;
      if (if1.taken_count !== 2'(want) || if1.not_taken_count !== 2'd0) begin
        n_fail++;
        $display("FAIL sat branch %0d counts: got %0d/%0d want %0d/0",
                 i, if1.taken_count, if1.not_taken_count, want);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_taken();
    test_not_taken();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
